// File: rtl/i2c_arb_pkg.sv
// ---------------------------------------------------------------------------
// i2c_arb_pkg
//   Shared types and widths for the i2c_master arbiter slice: FSM state
//   encoding, address/data widths of the i2c_master byte interface and a
//   helper that sizes the per-transaction timeout counter.
// ---------------------------------------------------------------------------
package i2c_arb_pkg;

   localparam int ADDR_W = 7;
   localparam int DATA_W = 8;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      ARB      = 3'd1,
      ISSUE    = 3'd2,
      COMPLETE = 3'd3,
      HOLDOFF  = 3'd4
   } arb_state_e;

   // Wide enough to hold the load value TIMEOUT_CYCLES itself.
   function automatic int tmo_cnt_width(input int cycles);
      return $clog2(cycles + 1);
   endfunction

endpackage

// File: rtl/i2c_rr_arbiter.sv
// ---------------------------------------------------------------------------
// i2c_rr_arbiter
//   Combinational round-robin picker. Searches req_i starting at ptr_i and
//   wrapping modulo NUM_REQ; the first set bit wins. When en_i is high and a
//   winner exists, ptr_nxt_o advances to the slot after the winner, otherwise
//   it returns ptr_i unchanged. The pointer register lives in the parent.
//
//   Ports
//     req_i      in   NUM_REQ  request vector
//     ptr_i      in   PW       current priority pointer
//     en_i       in   1        commit this arbitration (advance pointer)
//     gnt_o      out  NUM_REQ  one-hot grant (0 when nothing requested)
//     winner_o   out  PW       index of the winner
//     valid_o    out  1        at least one request present
//     ptr_nxt_o  out  PW       pointer value for the next cycle
// ---------------------------------------------------------------------------
module i2c_rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int PW      = 2
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [PW-1:0]      ptr_i,
   input  logic               en_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [PW-1:0]      winner_o,
   output logic               valid_o,
   output logic [PW-1:0]      ptr_nxt_o
);

   always_comb begin
      int idx;
      logic [PW-1:0] sel;
      valid_o  = 1'b0;
      winner_o = '0;
      idx      = 0;
      sel      = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = int'(ptr_i) + i;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         sel = PW'(idx);
         if (!valid_o && req_i[sel]) begin
            valid_o  = 1'b1;
            winner_o = sel;
         end
      end
   end

   assign gnt_o = valid_o ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << winner_o) : '0;

   always_comb begin
      ptr_nxt_o = ptr_i;
      if (en_i && valid_o) begin
         ptr_nxt_o = (winner_o == PW'(NUM_REQ - 1)) ? '0 : winner_o + PW'(1);
      end
   end

endmodule

// File: rtl/i2c_master_arbiter.sv
// ---------------------------------------------------------------------------
// i2c_master_arbiter
//   Shares one i2c_master between NUM_REQ clients with round-robin
//   arbitration. Latches the winner's rw/addr/wdata onto the master inputs,
//   holds start until the master's transaction_done rises, then pulses done
//   to the owner with the read byte and ACK status.
//
//   Optional build macro: I2C_ARB_TIMEOUT_EN
//     Adds a per-transaction timeout (TIMEOUT_CYCLES) and a HOLDOFF state
//     after a timed-out transaction so a late m_done is not credited to the
//     next owner. Without it rsp_timeout is tied 0 and ISSUE waits forever.
//
//   Ports
//     clk, reset         clock; asynchronous active-high reset
//     req/req_rw         per-client request level and R/W (1 = read)
//     req_addr/req_wdata per-client 7-bit address / write byte (packed)
//     grant              one-hot owner, held from issue through done
//     done               one-cycle completion pulse to the owner
//     rsp_rdata/rsp_ack  read byte and address ACK, valid in the done cycle
//     rsp_timeout        transaction aborted by timeout (done cycle)
//     m_start/m_rw/m_addr/m_wdata   to the i2c_master
//     m_rdata/m_done/m_ack          from the i2c_master
//
//   State | meaning
//   ------+-------------------------------------------------------------
//   IDLE     | no requests pending
//   ARB      | one cycle: pick winner, latch fields, set grant
//   ISSUE    | m_start high, waiting for m_done rising edge (or timeout)
//   COMPLETE | one cycle: done pulse to owner, grant released
//   HOLDOFF  | after a timeout: wait for a stale m_done edge or timeout
// ---------------------------------------------------------------------------
module i2c_master_arbiter
   import i2c_arb_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int TIMEOUT_CYCLES = 65536
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ-1:0]        req_rw,
   input  logic [ADDR_W*NUM_REQ-1:0] req_addr,
   input  logic [DATA_W*NUM_REQ-1:0] req_wdata,
   output logic [NUM_REQ-1:0]        grant,
   output logic [NUM_REQ-1:0]        done,
   output logic [DATA_W-1:0]         rsp_rdata,
   output logic                      rsp_ack,
   output logic                      rsp_timeout,
   output logic                      m_start,
   output logic                      m_rw,
   output logic [ADDR_W-1:0]         m_addr,
   output logic [DATA_W-1:0]         m_wdata,
   input  logic [DATA_W-1:0]         m_rdata,
   input  logic                      m_done,
   input  logic                      m_ack
);

   localparam int PW = $clog2(NUM_REQ);

   arb_state_e          state_q, state_d;
   logic [PW-1:0]       ptr_q, ptr_d;
   logic [NUM_REQ-1:0]  grant_q, grant_d;
   logic [NUM_REQ-1:0]  done_pulse_q, done_pulse_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                ack_q, ack_d;
   logic                m_start_q, m_start_d;
   logic                m_rw_q, m_rw_d;
   logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
   logic [DATA_W-1:0]   m_wdata_q, m_wdata_d;
   logic                mdone_q;
   logic                done_rise;

   logic [NUM_REQ-1:0]  arb_gnt;
   logic [PW-1:0]       arb_winner;
   logic                arb_valid;
   logic                arb_en;

   logic                win_rw;
   logic [ADDR_W-1:0]   win_addr;
   logic [DATA_W-1:0]   win_wdata;

`ifdef I2C_ARB_TIMEOUT_EN
   localparam int            TW       = tmo_cnt_width(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES);

   logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
   logic          tmo_flag_q, tmo_flag_d;
   logic          tmo_tc;

   assign tmo_tc = (tmo_cnt_q == TW'(1));
`else
   localparam int unused_tmo_cycles = TIMEOUT_CYCLES;
`endif

   // Only a fresh rising edge completes a transaction; a level left high
   // by the previous transaction is ignored.
   assign done_rise = m_done & ~mdone_q;
   assign arb_en    = (state_q == ARB);

   i2c_rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .PW      (PW)
   ) u_rr (
      .req_i     (req),
      .ptr_i     (ptr_q),
      .en_i      (arb_en),
      .gnt_o     (arb_gnt),
      .winner_o  (arb_winner),
      .valid_o   (arb_valid),
      .ptr_nxt_o (ptr_d)
   );

   // Field mux for the winner; constant slice bases keep the select simple.
   always_comb begin
      win_rw    = 1'b0;
      win_addr  = '0;
      win_wdata = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (arb_winner == PW'(i)) begin
            win_rw    = req_rw[i];
            win_addr  = req_addr[ADDR_W*i +: ADDR_W];
            win_wdata = req_wdata[DATA_W*i +: DATA_W];
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      done_pulse_d = '0;
      rdata_d      = rdata_q;
      ack_d        = ack_q;
      m_start_d    = m_start_q;
      m_rw_d       = m_rw_q;
      m_addr_d     = m_addr_q;
      m_wdata_d    = m_wdata_q;
`ifdef I2C_ARB_TIMEOUT_EN
      tmo_cnt_d    = tmo_cnt_q;
      tmo_flag_d   = tmo_flag_q;
`endif

      case (state_q)
         IDLE: begin
            if (|req) state_d = ARB;
         end

         ARB: begin
            if (arb_valid) begin
               grant_d   = arb_gnt;
               m_rw_d    = win_rw;
               m_addr_d  = win_addr;
               m_wdata_d = win_wdata;
               m_start_d = 1'b1;
               state_d   = ISSUE;
`ifdef I2C_ARB_TIMEOUT_EN
               tmo_cnt_d = TMO_LOAD;
`endif
            end else begin
               state_d = IDLE;
            end
         end

         ISSUE: begin
            if (done_rise) begin
               rdata_d      = m_rdata;
               ack_d        = m_ack;
               m_start_d    = 1'b0;
               done_pulse_d = grant_q;
               state_d      = COMPLETE;
`ifdef I2C_ARB_TIMEOUT_EN
               tmo_flag_d   = 1'b0;
            end else if (tmo_tc) begin
               rdata_d      = '0;
               ack_d        = 1'b0;
               m_start_d    = 1'b0;
               done_pulse_d = grant_q;
               tmo_flag_d   = 1'b1;
               state_d      = COMPLETE;
            end else begin
               tmo_cnt_d    = tmo_cnt_q - TW'(1);
`endif
            end
         end

         COMPLETE: begin
            grant_d = '0;
`ifdef I2C_ARB_TIMEOUT_EN
            if (tmo_flag_q) begin
               tmo_cnt_d = TMO_LOAD;
               state_d   = HOLDOFF;
            end else
`endif
            if (|req) state_d = ARB;
            else      state_d = IDLE;
         end

         HOLDOFF: begin
`ifdef I2C_ARB_TIMEOUT_EN
            if (done_rise || tmo_tc) begin
               state_d = (|req) ? ARB : IDLE;
            end else begin
               tmo_cnt_d = tmo_cnt_q - TW'(1);
            end
`else
            state_d = IDLE;
`endif
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         ptr_q        <= '0;
         grant_q      <= '0;
         done_pulse_q <= '0;
         rdata_q      <= '0;
         ack_q        <= 1'b0;
         m_start_q    <= 1'b0;
         m_rw_q       <= 1'b0;
         m_addr_q     <= '0;
         m_wdata_q    <= '0;
         mdone_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         grant_q      <= grant_d;
         done_pulse_q <= done_pulse_d;
         rdata_q      <= rdata_d;
         ack_q        <= ack_d;
         m_start_q    <= m_start_d;
         m_rw_q       <= m_rw_d;
         m_addr_q     <= m_addr_d;
         m_wdata_q    <= m_wdata_d;
         mdone_q      <= m_done;
      end
   end

`ifdef I2C_ARB_TIMEOUT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tmo_cnt_q  <= '0;
         tmo_flag_q <= 1'b0;
      end else begin
         tmo_cnt_q  <= tmo_cnt_d;
         tmo_flag_q <= tmo_flag_d;
      end
   end

   assign rsp_timeout = tmo_flag_q;
`else
   assign rsp_timeout = 1'b0;
`endif

   assign grant     = grant_q;
   assign done      = done_pulse_q;
   assign rsp_rdata = rdata_q;
   assign rsp_ack   = ack_q;
   assign m_start   = m_start_q;
   assign m_rw      = m_rw_q;
   assign m_addr    = m_addr_q;
   assign m_wdata   = m_wdata_q;

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// ---------------------------------------------------------------------------
// tb_i2c_master_arbiter
//   Directed bench for i2c_master_arbiter. A scoreboard queue holds the
//   expected owner, master fields and response of each transaction; the
//   bench plays the i2c_master, and pops/compares when done pulses.
// ---------------------------------------------------------------------------
module tb_i2c_master_arbiter;

   localparam int N = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic [N-1:0]  req;
   logic [N-1:0]  req_rw;
   logic [7*N-1:0] req_addr;
   logic [8*N-1:0] req_wdata;
   logic [N-1:0]  grant;
   logic [N-1:0]  done;
   logic [7:0]    rsp_rdata;
   logic          rsp_ack;
   logic          rsp_timeout;
   logic          m_start;
   logic          m_rw;
   logic [6:0]    m_addr;
   logic [7:0]    m_wdata;
   logic [7:0]    m_rdata;
   logic          m_done;
   logic          m_ack;

   typedef struct packed {
      logic [N-1:0] owner;
      logic         rw;
      logic [6:0]   addr;
      logic [7:0]   wdata;
      logic [7:0]   rdata;
      logic         ack;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   i2c_master_arbiter #(
      .NUM_REQ        (N),
      .TIMEOUT_CYCLES (100)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .req         (req),
      .req_rw      (req_rw),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .grant       (grant),
      .done        (done),
      .rsp_rdata   (rsp_rdata),
      .rsp_ack     (rsp_ack),
      .rsp_timeout (rsp_timeout),
      .m_start     (m_start),
      .m_rw        (m_rw),
      .m_addr      (m_addr),
      .m_wdata     (m_wdata),
      .m_rdata     (m_rdata),
      .m_done      (m_done),
      .m_ack       (m_ack)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_client(input int i, input logic rw, input logic [6:0] a, input logic [7:0] d);
      req_rw[i]          = rw;
      req_addr[7*i +: 7] = a;
      req_wdata[8*i +: 8] = d;
   endtask

   function automatic exp_t mk(input logic [N-1:0] owner, input logic rw, input logic [6:0] a,
                               input logic [7:0] wd, input logic [7:0] rd, input logic ack);
      exp_t e;
      e.owner = owner; e.rw = rw; e.addr = a; e.wdata = wd; e.rdata = rd; e.ack = ack;
      return e;
   endfunction

   // Plays the master for the transaction at the head of the scoreboard.
   task automatic txn(input int delay, input logic [N-1:0] req_after, input bit hold_done);
      exp_t e;
      int   n;
      bit   bad;
      check("sb_nonempty", 32'(sb.size() != 0), 1);
      if (sb.size() == 0) return;
      e = sb[0];
      n = 0;
      while (m_start !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      check("start_seen", m_start, 1);
      if (m_start !== 1'b1) return;
      check("grant_owner", grant, e.owner);
      check("grant_onehot", $countones(grant), 1);
      check("m_rw", m_rw, e.rw);
      check("m_addr", m_addr, e.addr);
      check("m_wdata", m_wdata, e.wdata);
      bad = 0;
      repeat (delay - 1) begin
         tick();
         if (done !== '0 || m_start !== 1'b1 || grant !== e.owner) bad = 1;
      end
      check("issue_stable", bad, 0);
      m_rdata = e.rdata;
      m_ack   = e.ack;
      m_done  = 1'b1;
      tick();
      e = sb.pop_front();
      check("done_pulse", done, e.owner);
      check("rsp_rdata", rsp_rdata, e.rdata);
      check("rsp_ack", rsp_ack, e.ack);
      check("rsp_timeout", rsp_timeout, 0);
      check("m_start_drop", m_start, 0);
      check("grant_held", grant, e.owner);
      req = req_after;
      tick();
      check("done_single", done, 0);
      check("m_start_gap", m_start, 0);
      if (!hold_done) m_done = 1'b0;
   endtask

   initial begin
      int n;
      bit bad;
      reset     = 1'b1;
      req       = '0;
      req_rw    = '0;
      req_addr  = '0;
      req_wdata = '0;
      m_rdata   = '0;
      m_done    = 1'b0;
      m_ack     = 1'b0;

      // reset state
      repeat (3) tick();
      check("rst_ctl", {grant, done, m_start, rsp_ack, rsp_timeout, m_rw}, 0);
      check("rst_data", {rsp_rdata, m_addr, m_wdata}, 0);
      reset = 1'b0;
      repeat (2) tick();
      check("idle_no_req", {grant, m_start}, 0);

      // single write, client 1, m_done 20 clk after start
      set_client(1, 1'b0, 7'h50, 8'hA5);
      sb.push_back(mk(4'b0010, 1'b0, 7'h50, 8'hA5, 8'h11, 1'b1));
      req = 4'b0010;
      txn(20, 4'b0000, 0);
      repeat (3) tick();
      check("idle_after_write", {grant, m_start}, 0);

      // read, client 0
      set_client(0, 1'b1, 7'h2A, 8'h00);
      sb.push_back(mk(4'b0001, 1'b1, 7'h2A, 8'h00, 8'h3C, 1'b1));
      req = 4'b0001;
      txn(7, 4'b0000, 0);
      repeat (2) tick();

      // stale m_done level carried into the next ISSUE
      set_client(2, 1'b0, 7'h33, 8'h5A);
      sb.push_back(mk(4'b0100, 1'b0, 7'h33, 8'h5A, 8'h91, 1'b0));
      sb.push_back(mk(4'b0100, 1'b0, 7'h33, 8'h5A, 8'h92, 1'b1));
      req = 4'b0100;
      txn(4, 4'b0100, 1);
      bad = 0;
      repeat (12) begin
         tick();
         if (done !== '0) bad = 1;
      end
      check("stale_no_done", bad, 0);
      check("stale_reissued", m_start, 1);
      m_done = 1'b0;
      txn(3, 4'b0000, 0);
      repeat (2) tick();

      // reset in ISSUE; pointer (3) would pick client 3 before reset
      set_client(2, 1'b1, 7'h44, 8'h21);
      set_client(3, 1'b0, 7'h45, 8'h22);
      req = 4'b1100;
      n = 0;
      while (m_start !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      check("pre_rst_grant", grant, 4'b1000);
      #2;
      reset = 1'b1;
      #1;
      check("async_rst_ctl", {grant, done, m_start, rsp_ack, rsp_timeout, m_rw}, 0);
      check("async_rst_data", {rsp_rdata, m_addr, m_wdata}, 0);
      tick();
      tick();
      reset = 1'b0;
      sb.push_back(mk(4'b0100, 1'b1, 7'h44, 8'h21, 8'hC3, 1'b1));
      sb.push_back(mk(4'b1000, 1'b0, 7'h45, 8'h22, 8'h5D, 1'b0));
      txn(5, 4'b1000, 0);
      txn(5, 4'b0000, 0);
      repeat (2) tick();

      // contention: all four held, expect 0,1,2,3,0
      for (int i = 0; i < N; i++) begin
         set_client(i, 1'(i & 1), 7'(8'h10 + i), 8'(8'h80 + i));
      end
      for (int k = 0; k < 5; k++) begin
         int c;
         c = k % N;
         sb.push_back(mk(4'(1 << c), 1'(c & 1), 7'(8'h10 + c), 8'(8'h80 + c), 8'(8'h40 + k), 1'(k & 1)));
      end
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         txn(2 + k, (k == 4) ? 4'b0000 : 4'b1111, 0);
      end
      repeat (3) tick();
      check("sb_drained", sb.size(), 0);

`ifdef I2C_ARB_TIMEOUT_EN
      // timeout: m_done never rises
      set_client(0, 1'b0, 7'h61, 8'h62);
      req = 4'b0001;
      n = 0;
      while (m_start !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      check("tmo_start", m_start, 1);
      n = 0;
      while (done === '0 && n < 200) begin
         tick();
         n++;
      end
      check("tmo_latency", n, 100);
      check("tmo_done", done, 4'b0001);
      check("tmo_flag", rsp_timeout, 1);
      check("tmo_rdata", rsp_rdata, 0);
      check("tmo_ack", rsp_ack, 0);
      tick();
      n = 1;
      while (grant === '0 && n < 300) begin
         tick();
         n++;
      end
      check("holdoff_len", n, 102);
      req = 4'b0000;
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
